// File: rtl/servo_ramp_ctrl.sv
// Servo position ramp controller.
// Accepts a target position code, clamps it to the legal travel range, and
// walks the PWM data word toward it by at most STEP_SIZE once every
// STEP_CYCLES clocks. Dropping arm disables the drive and freezes the position
// where it stands.
module servo_ramp_ctrl #(
  parameter int STEP_CYCLES = 1_000_000,
  parameter int STEP_SIZE   = 1,
  parameter int POS_MIN     = 25,
  parameter int POS_MAX     = 125,
  parameter int POS_INIT    = 75
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_pos,
  output logic        cmd_ready,
  output logic [15:0] data,
  output logic        en,
  output logic        busy,
  output logic        done
);

  localparam int TMR_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TICK_AT = TMR_W'(STEP_CYCLES - 1);

  localparam logic [15:0]        P_MIN  = 16'(POS_MIN);
  localparam logic [15:0]        P_MAX  = 16'(POS_MAX);
  localparam logic [15:0]        P_INIT = 16'(POS_INIT);
  localparam logic [15:0]        STEP_U = 16'(STEP_SIZE);
  localparam logic signed [16:0] STEP_S = 17'(STEP_SIZE);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    IDLE     = 2'd1,
    MOVE     = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       pos, pos_nxt;
  logic [15:0]       target, target_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic              done_nxt;
  logic              tick;
  logic [15:0]       cmd_clamped;
  logic [15:0]       pos_stepped;

  // Limit a requested code to the mechanical travel range.
  function automatic logic [15:0] clamp_pos(input logic [15:0] p);
    if (p < P_MIN)
      return P_MIN;
    else if (p > P_MAX)
      return P_MAX;
    else
      return p;
  endfunction

  // One step toward the target, never past it. The difference is taken as a
  // 17-bit signed value so both directions are handled without wrap-around.
  function automatic logic [15:0] step_toward(input logic [15:0] cur,
                                              input logic [15:0] tgt);
    logic signed [16:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff >= STEP_S)
      return cur + STEP_U;
    else if (diff <= -STEP_S)
      return cur - STEP_U;
    else
      return tgt;
  endfunction

  assign cmd_ready   = (state == IDLE);
  assign data        = pos;
  assign tick        = (timer == TICK_AT);
  assign cmd_clamped = clamp_pos(cmd_pos);
  assign pos_stepped = step_toward(pos, target);

  // Next-state, target, position and step-timer decisions; arm dominates.
  always_comb begin
    state_nxt  = state;
    pos_nxt    = pos;
    target_nxt = target;
    timer_nxt  = timer;
    done_nxt   = 1'b0;
    case (state)
      DISABLED: begin
        if (arm)
          state_nxt = IDLE;
      end
      IDLE: begin
        if (!arm) begin
          state_nxt  = DISABLED;
          target_nxt = pos;
          timer_nxt  = '0;
        end else if (cmd_valid) begin
          target_nxt = cmd_clamped;
          if (cmd_clamped != pos) begin
            state_nxt = MOVE;
            timer_nxt = '0;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      MOVE: begin
        if (!arm) begin
          state_nxt  = DISABLED;
          target_nxt = pos;
          timer_nxt  = '0;
        end else if (tick) begin
          timer_nxt = '0;
          pos_nxt   = pos_stepped;
          if (pos_stepped == target) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: begin
        state_nxt  = DISABLED;
        target_nxt = pos;
        timer_nxt  = '0;
      end
    endcase
  end

  // State, position and registered status outputs; reset restores mid-travel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DISABLED;
      pos    <= P_INIT;
      target <= P_INIT;
      timer  <= '0;
      en     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      pos    <= pos_nxt;
      target <= target_nxt;
      timer  <= timer_nxt;
      en     <= (state_nxt != DISABLED);
      busy   <= (state_nxt == MOVE);
      done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Bench for servo_ramp_ctrl: a reference model tracks mode and computes the
// ramp position in closed form from the handshake time; done events are
// queued by the model and popped by a monitor when the DUT raises done.
module tb_servo_ramp_ctrl;

  localparam int SC    = 4;
  localparam int SS    = 10;
  localparam int PMIN  = 25;
  localparam int PMAX  = 125;
  localparam int PINIT = 75;

  localparam int M_OFF  = 0;
  localparam int M_IDLE = 1;
  localparam int M_MOVE = 2;

  logic        clk = 1'b0;
  logic        rst, arm, cmd_valid;
  logic [15:0] cmd_pos;
  logic        cmd_ready, en, busy, done;
  logic [15:0] data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int m_mode  = M_OFF;
  int m_pos   = PINIT;
  int m_tgt   = PINIT;
  int m_start = PINIT;
  int m_el    = 0;
  bit m_done  = 1'b0;

  typedef struct {
    int pos;
    int cyc;
  } ev_t;
  ev_t done_q[$];

  servo_ramp_ctrl #(
    .STEP_CYCLES(SC),
    .STEP_SIZE  (SS),
    .POS_MIN    (PMIN),
    .POS_MAX    (PMAX),
    .POS_INIT   (PINIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .arm      (arm),
    .cmd_valid(cmd_valid),
    .cmd_pos  (cmd_pos),
    .cmd_ready(cmd_ready),
    .data     (data),
    .en       (en),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic int clampi(input int v);
    if (v < PMIN) return PMIN;
    if (v > PMAX) return PMAX;
    return v;
  endfunction

  // Position after el edges of ramping from s toward t, in closed form.
  function automatic int ramp_pos(input int s, input int t, input int el);
    int d, mag, ad;
    d   = t - s;
    ad  = (d < 0) ? -d : d;
    mag = SS * (el / SC);
    if (mag > ad) mag = ad;
    return (d < 0) ? s - mag : s + mag;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: expected state after each rising edge.
  always @(posedge clk) begin
    cyc++;
    m_done = 1'b0;
    if (rst) begin
      m_mode = M_OFF;
      m_pos  = PINIT;
      m_tgt  = PINIT;
      m_el   = 0;
    end else begin
      case (m_mode)
        M_OFF: if (arm) m_mode = M_IDLE;
        M_IDLE: begin
          if (!arm) m_mode = M_OFF;
          else if (cmd_valid) begin
            m_tgt = clampi(int'(cmd_pos));
            if (m_tgt == m_pos) begin
              m_done = 1'b1;
              done_q.push_back('{pos: m_pos, cyc: cyc});
            end else begin
              m_start = m_pos;
              m_el    = 0;
              m_mode  = M_MOVE;
            end
          end
        end
        default: begin
          if (!arm) m_mode = M_OFF;
          else begin
            m_el++;
            m_pos = ramp_pos(m_start, m_tgt, m_el);
            if (m_pos == m_tgt) begin
              m_mode = M_IDLE;
              m_done = 1'b1;
              done_q.push_back('{pos: m_pos, cyc: cyc});
            end
          end
        end
      endcase
    end
  end

  // Monitor: per-cycle output checks plus done-event scoreboard.
  always @(negedge clk) begin
    ev_t ev;
    chk("data", int'(data), m_pos);
    chk("en", int'(en), int'(m_mode != M_OFF));
    chk("busy", int'(busy), int'(m_mode == M_MOVE));
    chk("cmd_ready", int'(cmd_ready), int'(m_mode == M_IDLE));
    chk("done", int'(done), int'(m_done));
    chk("range", int'(data >= 16'(PMIN) && data <= 16'(PMAX)), 1);
    if (done) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        ev = done_q.pop_front();
        chk("done_pos", int'(data), ev.pos);
        chk("done_cycle", cyc, ev.cyc);
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (m_mode != M_IDLE && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_ready", int'(cmd_ready), 1);
  endtask

  task automatic issue(input logic [15:0] p);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_pos   = p;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    arm       = 1'b0;
    cmd_valid = 1'b0;
    cmd_pos   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    arm = 1'b1;
    wait_idle(5);

    issue(16'd100);  wait_idle(100);
    issue(16'd0);    wait_idle(100);
    issue(16'd500);  wait_idle(100);
    issue(16'd75);   wait_idle(100);
    issue(16'd75);   wait_idle(100);
    repeat (2) @(negedge clk);

    // Drop arm mid-ramp once the position reaches 95, then re-arm.
    issue(16'd125);
    n = 0;
    while (m_pos != 95 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("reach_95", int'(data), 95);
    arm = 1'b0;
    repeat (3) @(negedge clk);
    arm = 1'b1;
    repeat (8) @(negedge clk);

    // Command held valid throughout a move.
    cmd_valid = 1'b1;
    cmd_pos   = 16'd40;
    repeat (40) @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle(100);

    // Reset in the middle of a move.
    issue(16'd125);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Randomized traffic.
    repeat (600) begin
      @(negedge clk);
      rst       = (($urandom % 100) == 0);
      arm       = (($urandom % 40) != 0);
      cmd_valid = (($urandom % 4) == 0);
      cmd_pos   = (($urandom % 8) == 0) ? 16'($urandom) : 16'($urandom_range(0, 200));
    end
    @(negedge clk);
    rst       = 1'b0;
    arm       = 1'b1;
    cmd_valid = 1'b0;
    wait_idle(400);
    repeat (3) @(negedge clk);
    chk("queue_drained", done_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
